// File: rtl/mm_col_drive_timer_pkg.sv
// Shared mux types used by the column drive timer.
// PFS: column addressing. MM_STATES: mux states and the drive-timer phases.
package PFS;
  localparam int MOTOR_COLS = 8;
  localparam int COL_W      = $clog2(MOTOR_COLS);
  typedef logic [COL_W-1:0] col_addr_t;
endpackage

package MM_STATES;
  typedef enum logic [1:0] {
    MM_IDLE,
    MM_SCAN,
    DRIVE,
    FINALIZE
  } mm_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_PRE,
    T_ON,
    T_POST,
    T_DONE,
    T_WAIT
  } drv_phase_t;
endpackage

// File: rtl/mm_col_drive_timer_phase_counter.sv
// mm_phase_counter: loadable down-counter with a zero flag.
// A load takes priority. A decrement only happens while the count is nonzero,
// so the count can never wrap.
module mm_phase_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins; otherwise count down, saturating at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mm_col_drive_timer.sv
// mm_col_drive_timer: per-column drive window sequencer for the motor mux.
// The window runs: pre dead-time, on-time (drive_en high), post dead-time,
// and then a one-cycle col_done pulse.
// Optional feature: define MM_DRIVE_DEAD_TIME_EN to enable the pre and post
// dead-time phases. When it is undefined, the window is on-time followed by done.
//
// One shared counter holds "phase length - 1". The FSM leaves a timed phase in
// the cycle the counter reads zero, so a phase of length L lasts exactly L cycles.
module mm_col_drive_timer
  import MM_STATES::*;
  import PFS::*;
#(
  parameter int CNT_W     = 16,
  parameter int DEAD_TIME = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  mm_state_t        state,
  input  col_addr_t        col,
  input  col_addr_t        last_active_col,
  input  logic [CNT_W-1:0] drive_ticks,
  output logic             drive_en,
  output logic             col_done,
  output logic             last_col,
  output logic             busy
);

`ifdef MM_DRIVE_DEAD_TIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif
  localparam int EFF_DEAD = DEAD_EN ? DEAD_TIME : 0;
  localparam logic [CNT_W-1:0] DEAD_LOAD = (EFF_DEAD > 0) ? CNT_W'(EFF_DEAD - 1) : '0;

  drv_phase_t       phase_q, phase_d;
  logic [CNT_W-1:0] ticks_q, ticks_d;
  logic             drive_en_q, col_done_q, busy_q, last_col_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             in_drive;

  assign in_drive = (state == DRIVE);

  mm_phase_counter #(.W(CNT_W)) u_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next phase and counter control. Leaving DRIVE aborts any active phase.
  always_comb begin
    phase_d  = phase_q;
    ticks_d  = ticks_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (phase_q)
      T_IDLE: begin
        if (in_drive) begin
          ticks_d  = drive_ticks;
          cnt_load = 1'b1;
          if (EFF_DEAD != 0) begin
            phase_d = T_PRE;
            cnt_val = DEAD_LOAD;
          end else if (drive_ticks == '0) begin
            phase_d = T_DONE;
          end else begin
            phase_d = T_ON;
            cnt_val = drive_ticks - CNT_W'(1);
          end
        end
      end
      T_PRE: begin
        if (!in_drive) begin
          phase_d = T_IDLE;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          if (ticks_q == '0) begin
            phase_d = T_POST;
            cnt_val = DEAD_LOAD;
          end else begin
            phase_d = T_ON;
            cnt_val = ticks_q - CNT_W'(1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      T_ON: begin
        if (!in_drive) begin
          phase_d = T_IDLE;
        end else if (cnt_zero) begin
          if (EFF_DEAD != 0) begin
            phase_d  = T_POST;
            cnt_load = 1'b1;
            cnt_val  = DEAD_LOAD;
          end else begin
            phase_d = T_DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      T_POST: begin
        if (!in_drive) begin
          phase_d = T_IDLE;
        end else if (cnt_zero) begin
          phase_d = T_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      T_DONE: begin
        phase_d = in_drive ? T_WAIT : T_IDLE;
      end
      T_WAIT: begin
        if (!in_drive) begin
          phase_d = T_IDLE;
        end
      end
      default: phase_d = T_IDLE;
    endcase
  end

  // Phase and latched on-time. The outputs are registered from the next phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= T_IDLE;
      ticks_q    <= '0;
      drive_en_q <= 1'b0;
      col_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      ticks_q    <= ticks_d;
      drive_en_q <= (phase_d == T_ON);
      col_done_q <= (phase_d == T_DONE);
      busy_q     <= (phase_d != T_IDLE);
    end
  end

  // Last-column flag, independent of the window FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_col_q <= 1'b0;
    end else begin
      last_col_q <= (col == last_active_col);
    end
  end

  assign drive_en = drive_en_q;
  assign col_done = col_done_q;
  assign busy     = busy_q;
  assign last_col = last_col_q;

endmodule
